// File: rtl/apb_master_mc.sv
// APB3 master: valid/ready command port to NUM_SLAVES slaves, one response per command.
// Optional APB4 write strobes when APB_PSTRB_EN is defined. Zero-wait latency accept->rsp_valid 3 cycles.
module apb_master_mc #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 4,
    parameter int SEL_LSB    = 12,
    parameter int SEL_W      = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_write,
    input  logic [ADDR_W-1:0]            cmd_addr,
    input  logic [DATA_W-1:0]            cmd_wdata,
`ifdef APB_PSTRB_EN
    input  logic [DATA_W/8-1:0]          cmd_strb,
    output logic [DATA_W/8-1:0]          PSTRB,
`endif
    output logic                         rsp_valid,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         rsp_err,
    output logic                         rsp_timeout,
    output logic [NUM_SLAVES-1:0]        PSEL,
    output logic                         PENABLE,
    output logic                         PWRITE,
    output logic [ADDR_W-1:0]            PADDR,
    output logic [DATA_W-1:0]            PWDATA,
    input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]        PREADY,
    input  logic [NUM_SLAVES-1:0]        PSLVERR
);

    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                  state_q, state_d;
    logic [NUM_SLAVES-1:0]   psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]       paddr_q, paddr_d;
    logic [DATA_W-1:0]       pwdata_q, pwdata_d;
    logic [CNT_W-1:0]        wait_cnt_q, wait_cnt_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]       rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    rsp_timeout_q, rsp_timeout_d;
`ifdef APB_PSTRB_EN
    logic [DATA_W/8-1:0]     pstrb_q, pstrb_d;
`endif

    logic [SEL_W-1:0]        sel_idx;
    logic                    sel_ready;
    logic                    sel_err;
    logic [DATA_W-1:0]       sel_rdata;

    // psel_q is one-hot, so masking with it picks the addressed slave's response
    always_comb begin
        sel_idx   = cmd_addr[SEL_LSB +: SEL_W];
        sel_ready = |(PREADY & psel_q);
        sel_err   = |(PSLVERR & psel_q);
        sel_rdata = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (psel_q[k]) begin
                sel_rdata = sel_rdata | PRDATA[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        wait_cnt_d    = wait_cnt_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
`ifdef APB_PSTRB_EN
        pstrb_d       = pstrb_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    pwrite_d = cmd_write;
`ifdef APB_PSTRB_EN
                    pstrb_d  = cmd_write ? cmd_strb : '0;
`endif
                    if (32'(sel_idx) < 32'(NUM_SLAVES)) begin
                        psel_d  = NUM_SLAVES'(1) << sel_idx;
                        state_d = SETUP;
                    end else begin
                        state_d       = RESP;
                        rsp_valid_d   = 1'b1;
                        rsp_rdata_d   = '0;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b0;
                    end
                end
            end
            SETUP: begin
                penable_d  = 1'b1;
                wait_cnt_d = '0;
                state_d    = ACCESS;
            end
            ACCESS: begin
                if (sel_ready) begin
                    state_d       = RESP;
                    psel_d        = '0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = sel_err;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = (pwrite_q || sel_err) ? '0 : sel_rdata;
                end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d       = RESP;
                    psel_d        = '0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q       <= IDLE;
            psel_q        <= '0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            wait_cnt_q    <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
`ifdef APB_PSTRB_EN
            pstrb_q       <= '0;
`endif
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            wait_cnt_q    <= wait_cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
`ifdef APB_PSTRB_EN
            pstrb_q       <= pstrb_d;
`endif
        end
    end

    assign cmd_ready   = (state_q == IDLE) && !PRESET;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
`ifdef APB_PSTRB_EN
    assign PSTRB       = pstrb_q;
`endif

endmodule

// File: tb/tb_apb_master_mc.sv
// Bench for apb_master_mc: 4 slaves, 3-bit select field (indices 4..7 are decode errors), TIMEOUT=16.
module tb_apb_master_mc;

    localparam int NS = 4;

    logic          clk;
    logic          preset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [31:0]   cmd_addr;
    logic [31:0]   cmd_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic [NS-1:0] psel;
    logic          penable;
    logic          pwrite;
    logic [31:0]   paddr;
    logic [31:0]   pwdata;
    logic [NS*32-1:0] prdata;
    logic [NS-1:0] pready;
    logic [NS-1:0] pslverr;
`ifdef APB_PSTRB_EN
    logic [3:0]    cmd_strb;
    logic [3:0]    pstrb;
`endif

    apb_master_mc #(
        .ADDR_W(32), .DATA_W(32), .NUM_SLAVES(NS), .SEL_LSB(12), .SEL_W(3), .TIMEOUT(16)
    ) dut (
        .PCLK(clk), .PRESET(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
`ifdef APB_PSTRB_EN
        .cmd_strb(cmd_strb), .PSTRB(pstrb),
`endif
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
        .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;
        bit          slverr;
        logic [3:0]  exp_psel;
        logic [31:0] exp_rdata;
        bit          exp_err;
        bit          exp_to;
        int          exp_acc;
    } vec_t;

    vec_t vecs[11];
    vec_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   acc_cnt = 0;
    int   acc_seen = 0;
    int   cur_waits = 0;
    bit   cur_err = 1'b0;

    // Slave model: unselected slaves answer ready/error with their own data so a wrong pick shows up
    always_comb begin
        for (int k = 0; k < NS; k++) begin
            prdata[k*32 +: 32] = (k == 2) ? 32'hDEADBEEF : (32'hA0A0_0000 + 32'(k));
            pready[k]          = psel[k] ? (acc_cnt >= cur_waits) : 1'b1;
            pslverr[k]         = psel[k] ? cur_err : 1'b1;
        end
    end

    always @(posedge clk) acc_cnt <= penable ? acc_cnt + 1 : 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Monitor samples exactly at negedge; the driver acts 1 time unit later
    always @(negedge clk) begin
        vec_t e;
        if (cmd_ready) acc_seen = 0;
        if (psel != 0 || penable) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_bus: got psel %h expected no transfer", psel);
            end else begin
                e = exp_q[0];
                chk(penable ? "access_psel" : "setup_psel", 32'(psel), 32'(e.exp_psel));
                chk("paddr", paddr, e.addr);
                chk("pwdata", pwdata, e.wdata);
                chk("pwrite", 32'(pwrite), 32'(e.wr));
`ifdef APB_PSTRB_EN
                chk("pstrb", 32'(pstrb), e.wr ? 32'(e.strb) : 32'd0);
`endif
                if (penable) acc_seen++;
            end
        end
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_rsp: got rsp_valid 1 expected 0");
            end else begin
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.exp_rdata);
                chk("rsp_err", 32'(rsp_err), 32'(e.exp_err));
                chk("rsp_timeout", 32'(rsp_timeout), 32'(e.exp_to));
                chk("access_cycles", 32'(acc_seen), 32'(e.exp_acc));
            end
        end
    end

    task automatic issue(input vec_t v);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            step();
            n++;
        end
        if (!cmd_ready) begin
            n_cmp++; n_fail++;
            $display("FAIL cmd_ready_wait: got 0 expected 1");
        end
        cur_waits = v.waits;
        cur_err   = v.slverr;
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
`ifdef APB_PSTRB_EN
        cmd_strb  = v.strb;
`endif
        exp_q.push_back(v);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!rsp_valid && n < 100) begin
            step();
            n++;
        end
        if (!rsp_valid) begin
            n_cmp++; n_fail++;
            $display("FAIL rsp_wait: got no rsp_valid expected one within 100 cycles");
        end
        step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_psel"}, 32'(psel), 32'd0);
        chk({tag, "_penable"}, 32'(penable), 32'd0);
        chk({tag, "_pwrite"}, 32'(pwrite), 32'd0);
        chk({tag, "_paddr"}, paddr, 32'd0);
        chk({tag, "_pwdata"}, pwdata, 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        chk({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'd0);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
`ifdef APB_PSTRB_EN
        chk({tag, "_pstrb"}, 32'(pstrb), 32'd0);
`endif
    endtask

    initial begin
        vec_t v;
        int   n;
        //           wr  addr          wdata          strb     waits slverr psel     rdata          err to  acc
        vecs[0]  = '{1, 32'h0000_1020, 32'h0000_0009, 4'b0101, 0,    0,     4'b0010, 32'h0,         0,  0,  1};
        vecs[1]  = '{0, 32'h0000_2004, 32'h0,         4'b1111, 3,    0,     4'b0100, 32'hDEADBEEF,  0,  0,  4};
        vecs[2]  = '{0, 32'h0000_3010, 32'h55,        4'b1111, 0,    1,     4'b1000, 32'h0,         1,  0,  1};
        vecs[3]  = '{0, 32'h0000_0000, 32'h0,         4'b0000, 1000, 0,     4'b0001, 32'h0,         1,  1,  16};
        vecs[4]  = '{0, 32'h0000_4000, 32'h0,         4'b0000, 0,    0,     4'b0000, 32'h0,         1,  0,  0};
        vecs[5]  = '{1, 32'h0000_7FFC, 32'h1234,      4'b1111, 0,    0,     4'b0000, 32'h0,         1,  0,  0};
        vecs[6]  = '{0, 32'h0000_1008, 32'h0,         4'b0000, 1,    0,     4'b0010, 32'hA0A0_0001, 0,  0,  2};
        vecs[7]  = '{1, 32'h0000_0100, 32'hCAFEF00D,  4'b1010, 2,    1,     4'b0001, 32'h0,         1,  0,  3};
        vecs[8]  = '{0, 32'h0000_3FFC, 32'h0,         4'b0000, 15,   0,     4'b1000, 32'hA0A0_0003, 0,  0,  16};
        vecs[9]  = '{1, 32'h0000_2000, 32'hFFFFFFFF,  4'b0011, 14,   0,     4'b0100, 32'h0,         0,  0,  15};
        vecs[10] = '{1, 32'h0000_0ABC, 32'h1,         4'b1111, 1000, 1,     4'b0001, 32'h0,         1,  1,  16};

        preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
`ifdef APB_PSTRB_EN
        cmd_strb = '0;
`endif
        step(); step();
        chk_all_zero("reset");
        preset = 1'b0;
        #1;
        chk("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);

        // Zero-wait write, cycle by cycle
        issue(vecs[0]);
        chk("t1_psel", 32'(psel), 32'b0010);
        chk("t1_penable", 32'(penable), 32'd0);
        chk("t1_cmd_ready", 32'(cmd_ready), 32'd0);
        step();
        chk("t2_psel", 32'(psel), 32'b0010);
        chk("t2_penable", 32'(penable), 32'd1);
        step();
        chk("t3_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t3_psel", 32'(psel), 32'd0);
        chk("t3_penable", 32'(penable), 32'd0);
        chk("t3_cmd_ready", 32'(cmd_ready), 32'd0);
        step();
        chk("t4_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t4_cmd_ready", 32'(cmd_ready), 32'd1);

        for (int i = 1; i < 11; i++) begin
            issue(vecs[i]);
            wait_rsp();
        end

        // Decode error answers in the cycle right after accept; fields hold afterwards
        v = '{0, 32'h0000_5000, 32'h0, 4'b0000, 0, 0, 4'b0000, 32'h0, 1, 0, 0};
        issue(v);
        chk("dec_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("dec_psel", 32'(psel), 32'd0);
        step();
        chk("dec_rsp_valid_drop", 32'(rsp_valid), 32'd0);
        chk("dec_rsp_err_hold", 32'(rsp_err), 32'd1);
        chk("dec_cmd_ready", 32'(cmd_ready), 32'd1);

        // Reset in the middle of ACCESS kills the command silently
        v = '{0, 32'h0000_2000, 32'h0, 4'b0000, 1000, 0, 4'b0100, 32'h0, 1, 1, 16};
        issue(v);
        n = 0;
        while (!penable && n < 10) begin
            step();
            n++;
        end
        chk("kill_in_access", 32'(penable), 32'd1);
        step();
        preset = 1'b1;
        void'(exp_q.pop_front());
        step();
        chk_all_zero("kill");
        preset = 1'b0;
        #1;
        chk("kill_cmd_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("kill_no_rsp", 32'(rsp_valid), 32'd0);
        end
        issue(vecs[1]);
        wait_rsp();

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
